sq_integral_sequencer: RTL and testbench
========================================

SQ_INTEGRAL_SEQUENCER -- requirements
Module: sq_integral_sequencer

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- IMG_W, 8, image width in pixels.
- IMG_H, 6, image height in pixels.
- WORDS, 4, words per cache block (window cache blocking).
- PIX_BITS, 8, input pixel depth.
- WORD_SIZE, 22, squared-sum word width.
REQ-002 Derived localparams SHALL be:
- ROW_W = bits for 0..IMG_W.
- COL_W = bits for 0..IMG_H.
- BLK_W = bits for 0..ceil((IMG_W+1)/WORDS)-1.
REQ-003 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  begin one frame.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last cache write.
- pix_valid  in  1  pixel available.
- pix_ready  out  1  pixel accepted when valid&ready.
- pix_data  in  PIX_BITS  raster-order pixel.
- we  out  1  cache write enable.
- waddrY  out  COL_W  cache write row.
- waddrX  out  ROW_W  cache write column.
- wdata  out  WORD_SIZE  cache write data.
- raddrY  out  COL_W  cache read row.
- raddrXBlock  out  BLK_W  cache read block.
- q  in  WORDS*WORD_SIZE  cache read block data, word k at bits [k*WORD_SIZE +: WORD_SIZE].

Function
REQ-004 The FSM SHALL have states IDLE, CLEAR, COL0, FETCH, READ, WRITE.
REQ-005 IDLE: on start=1, go to CLEAR with x=0, y=0 and busy=1; start SHALL be ignored in every other state.
REQ-006 CLEAR: write 0 to (y=0, x) for x=0..IMG_W, one write per cycle (IMG_W+1 cycles); then go to COL0 with y=1.
REQ-007 COL0: write 0 to (y, 0) in one cycle, clear rowsum to 0, set x=1, go to FETCH.
REQ-008 FETCH: pix_ready=1.
- Without a handshake, hold state; no writes.
- On handshake: rowsum <= rowsum + pix_data*pix_data, then go to READ.
REQ-009 READ: drive raddrY=y-1 and raddrXBlock=x/WORDS for one cycle, then go to WRITE.
REQ-010 Cache read latency is 1 cycle, so q SHALL be sampled in WRITE.
REQ-011 WRITE: we=1, waddrY=y, waddrX=x, wdata = rowsum + q word (x mod WORDS).
- If x<IMG_W: increment x, go to FETCH.
- Else if y<IMG_H: increment y, go to COL0.
- Else: go to IDLE with done=1 for exactly that next cycle and busy=0.
REQ-012 Arithmetic SHALL be unsigned.
- pix_data*pix_data is 2*PIX_BITS wide, zero-extended.
- rowsum and wdata are WORD_SIZE wide and wrap modulo 2^WORD_SIZE; no saturation.
REQ-013 pix_ready SHALL be 1 only in FETCH; we SHALL be 1 only in CLEAR, COL0 and WRITE.
REQ-014 raddr outputs SHALL hold their last value outside READ.
REQ-015 With continuous pix_valid, a frame SHALL take (IMG_W+1) + IMG_H*(1+3*IMG_W) cycles from start to the last write.
REQ-016 Each pixel is accepted exactly once; no pixel is consumed outside FETCH.

Reset
REQ-017 rst=1 SHALL asynchronously force state IDLE.
REQ-018 During reset, all outputs (busy, done, pix_ready, we, waddrY, waddrX, wdata, raddrY, raddrXBlock) and internal x, y, rowsum SHALL be 0.
REQ-019 Reset mid-frame SHALL abandon the frame with no further writes and no done pulse; the next start begins a fresh frame at CLEAR.

Verification
REQ-020 All-ones 8x6 frame with continuous valid and a cache model:
- Exactly 9 writes of 0 to row 0 and 0 in column 0 of rows 1..6.
- (y,x) = x*y, e.g. (6,8)=48.
- done occurs 159 cycles after start.
REQ-021 All pixels 255 -> (6,8) = 48*65025 = 3121200; (1,1) = 65025.
REQ-022 pix_valid low for 5 cycles at pixel (2,3) -> FSM holds FETCH, we=0 throughout, final image identical to REQ-020.
REQ-023 Block addressing: at x=4 read raddrXBlock=1 and word 0; at x=7 read block 1, word 3; at x=8 read block 2, word 0.
REQ-024 start pulsed while busy -> ignored, single done.
- rst asserted at pixel (3,5) -> all outputs 0 immediately.
- A new start then yields the correct full frame.

Source files
------------

// File: rtl/sq_integral_sequencer.sv
// Squared-pixel integral image sequencer: streams a raster frame in, and for every
// pixel reads the row above from a blocked cache and writes the running integral back.
module sq_integral_sequencer #(
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 6,
  parameter int WORDS     = 4,
  parameter int PIX_BITS  = 8,
  parameter int WORD_SIZE = 22,
  localparam int ROW_W    = $clog2(IMG_W + 1),
  localparam int COL_W    = $clog2(IMG_H + 1),
  localparam int NBLK     = (IMG_W + WORDS) / WORDS,
  localparam int BLK_W    = (NBLK > 1) ? $clog2(NBLK) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  input  logic [PIX_BITS-1:0]        pix_data,
  output logic                       we,
  output logic [COL_W-1:0]           waddrY,
  output logic [ROW_W-1:0]           waddrX,
  output logic [WORD_SIZE-1:0]       wdata,
  output logic [COL_W-1:0]           raddrY,
  output logic [BLK_W-1:0]           raddrXBlock,
  input  logic [WORDS*WORD_SIZE-1:0] q
);

  typedef enum logic [2:0] {IDLE, CLEAR, COL0, FETCH, READ, WRITE} state_t;

  localparam logic [ROW_W-1:0] X_LAST = ROW_W'(IMG_W);
  localparam logic [COL_W-1:0] Y_LAST = COL_W'(IMG_H);

  state_t                  state, state_n;
  logic [ROW_W-1:0]        x;
  logic [COL_W-1:0]        y;
  logic [WORD_SIZE-1:0]    rowsum;
  logic [2*PIX_BITS-1:0]   sq;
  logic [ROW_W-1:0]        widx;
  logic [WORD_SIZE-1:0]    qword;
  logic                    hs;

  // Pixel handshake: a pixel transfers on a rising edge where pix_valid and
  // pix_ready are both 1; pix_ready is raised only while waiting in FETCH.
  assign hs   = pix_valid && pix_ready;
  assign sq   = {{PIX_BITS{1'b0}}, pix_data} * {{PIX_BITS{1'b0}}, pix_data};
  assign widx = x % ROW_W'(WORDS);

  always_comb begin
    qword = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (widx == ROW_W'(k)) qword = q[k*WORD_SIZE +: WORD_SIZE];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      rowsum      <= '0;
      raddrY      <= '0;
      raddrXBlock <= '0;
      done        <= 1'b0;
    end else begin
      state <= state_n;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x <= '0;
            y <= '0;
          end
        end
        CLEAR: begin
          if (x == X_LAST) begin
            x <= '0;
            y <= COL_W'(1);
          end else begin
            x <= x + ROW_W'(1);
          end
        end
        COL0: begin
          rowsum <= '0;
          x      <= ROW_W'(1);
        end
        FETCH: begin
          // Read address is loaded here so it is stable for the whole READ cycle.
          if (hs) begin
            rowsum      <= rowsum + WORD_SIZE'(sq);
            raddrY      <= y - COL_W'(1);
            raddrXBlock <= BLK_W'(x / ROW_W'(WORDS));
          end
        end
        WRITE: begin
          if (x != X_LAST) begin
            x <= x + ROW_W'(1);
          end else if (y != Y_LAST) begin
            y <= y + COL_W'(1);
            x <= '0;
          end else begin
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n   = state;
    pix_ready = 1'b0;
    we        = 1'b0;
    case (state)
      IDLE:  if (start) state_n = CLEAR;
      CLEAR: begin
        we = 1'b1;
        if (x == X_LAST) state_n = COL0;
      end
      COL0: begin
        we      = 1'b1;
        state_n = FETCH;
      end
      FETCH: begin
        pix_ready = 1'b1;
        if (pix_valid) state_n = READ;
      end
      READ:  state_n = WRITE;
      WRITE: begin
        we = 1'b1;
        if (x != X_LAST)      state_n = FETCH;
        else if (y != Y_LAST) state_n = COL0;
        else                  state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy   = (state != IDLE);
  assign waddrY = we ? y : '0;
  assign waddrX = we ? x : '0;
  assign wdata  = (state == WRITE) ? (rowsum + qword) : '0;

endmodule

// File: tb/tb_sq_integral_sequencer.sv
// Bench for sq_integral_sequencer: blocked cache model, raster pixel driver and a
// write scoreboard fed from a recurrence-based integral image model.
module tb_sq_integral_sequencer;

  localparam int IMG_W     = 8;
  localparam int IMG_H     = 6;
  localparam int WORDS     = 4;
  localparam int PIX_BITS  = 8;
  localparam int WORD_SIZE = 22;
  localparam int ROW_W     = 4;
  localparam int COL_W     = 3;
  localparam int BLK_W     = 2;
  localparam int NPIX      = IMG_W * IMG_H;
  localparam int EW        = COL_W + ROW_W + WORD_SIZE;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                       start = 1'b0;
  logic                       pix_valid = 1'b0;
  logic [PIX_BITS-1:0]        pix_data = '0;
  logic                       busy, done, pix_ready, we;
  logic [COL_W-1:0]           waddrY, raddrY;
  logic [ROW_W-1:0]           waddrX;
  logic [BLK_W-1:0]           raddrXBlock;
  logic [WORD_SIZE-1:0]       wdata;
  logic [WORDS*WORD_SIZE-1:0] q;

  sq_integral_sequencer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .WORDS(WORDS), .PIX_BITS(PIX_BITS), .WORD_SIZE(WORD_SIZE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .we(we), .waddrY(waddrY), .waddrX(waddrX), .wdata(wdata),
    .raddrY(raddrY), .raddrXBlock(raddrXBlock), .q(q)
  );

  // cache model: one-cycle read latency, garbage-filled before each frame
  logic [WORD_SIZE-1:0] mem [0:IMG_H][0:IMG_W];
  logic scramble = 1'b0;
  always @(posedge clk) begin
    int cx;
    if (scramble) begin
      for (int yy = 0; yy <= IMG_H; yy++)
        for (int xx = 0; xx <= IMG_W; xx++)
          mem[yy][xx] <= WORD_SIZE'($urandom);
    end else if (we) begin
      mem[waddrY][waddrX] <= wdata;
    end
    for (int k = 0; k < WORDS; k++) begin
      cx = int'(raddrXBlock) * WORDS + k;
      q[k*WORD_SIZE +: WORD_SIZE] <= (cx <= IMG_W && int'(raddrY) <= IMG_H) ? mem[raddrY][cx] : '0;
    end
  end

  // checking
  int n_checks = 0;
  int n_pass   = 0;
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_busy"}, busy, 0);
    check_eq({pfx, "_done"}, done, 0);
    check_eq({pfx, "_pix_ready"}, pix_ready, 0);
    check_eq({pfx, "_we"}, we, 0);
    check_eq({pfx, "_waddrY"}, waddrY, 0);
    check_eq({pfx, "_waddrX"}, waddrX, 0);
    check_eq({pfx, "_wdata"}, wdata, 0);
    check_eq({pfx, "_raddrY"}, raddrY, 0);
    check_eq({pfx, "_raddrXBlock"}, raddrXBlock, 0);
  endtask

  // reference model: integral of squared pixels via the 2-D recurrence
  logic [PIX_BITS-1:0]  pix   [0:NPIX-1];
  logic [WORD_SIZE-1:0] integ [0:IMG_H][0:IMG_W];
  logic [EW-1:0]        exp_q [$];

  task automatic fill_pix(input int mode);
    for (int i = 0; i < NPIX; i++)
      pix[i] = (mode == 0) ? 8'd1 : (mode == 1) ? 8'd255 : PIX_BITS'($urandom_range(0, 255));
  endtask

  task automatic build_model();
    int p;
    for (int yy = 0; yy <= IMG_H; yy++)
      for (int xx = 0; xx <= IMG_W; xx++)
        integ[yy][xx] = '0;
    for (int yy = 1; yy <= IMG_H; yy++)
      for (int xx = 1; xx <= IMG_W; xx++) begin
        p = int'(pix[(yy-1)*IMG_W + xx - 1]);
        integ[yy][xx] = integ[yy-1][xx] + integ[yy][xx-1] - integ[yy-1][xx-1] + WORD_SIZE'(p * p);
      end
    exp_q.delete();
    for (int xx = 0; xx <= IMG_W; xx++) exp_q.push_back({COL_W'(0), ROW_W'(xx), WORD_SIZE'(0)});
    for (int yy = 1; yy <= IMG_H; yy++)
      for (int xx = 0; xx <= IMG_W; xx++)
        exp_q.push_back({COL_W'(yy), ROW_W'(xx), integ[yy][xx]});
  endtask

  // monitor: write scoreboard, read-address check in the cycle after each handshake
  int done_cnt = 0;
  int extra_wr = 0;
  int hs_cnt   = 0;
  logic pend   = 1'b0;
  int pend_y, pend_x;
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst) begin
      pend   = 1'b0;
      hs_cnt = 0;
    end else begin
      if (start && !busy) hs_cnt = 0;
      if (pend) begin
        check_eq("raddrY", raddrY, 64'(pend_y - 1));
        check_eq("raddrXBlock", raddrXBlock, 64'(pend_x / WORDS));
      end
      pend = pix_valid && pix_ready;
      if (pend) begin
        pend_y = hs_cnt / IMG_W + 1;
        pend_x = hs_cnt % IMG_W + 1;
        hs_cnt++;
      end
      if (done) done_cnt++;
      if (we) begin
        if (exp_q.size() == 0) extra_wr++;
        else begin
          e = exp_q.pop_front();
          check_eq("write", {waddrY, waddrX, wdata}, e);
        end
      end
    end
  end

  // driver: inputs change 1 time unit after the rising edge
  task automatic drive_frame(input int stall_at, input int stall_len, input int abort_at,
                             input bit rand_gaps);
    bit got;
    for (int i = 0; i < NPIX; i++) begin
      if (i == stall_at || i == abort_at) begin
        pix_valid = 1'b0;
        got = 1'b0;
        for (int b = 0; b < 50 && !got; b++) begin
          @(negedge clk);
          got = pix_ready;
          if (!got) begin @(posedge clk); #1; end
        end
        check_eq("reach_fetch", got, 1);
        if (i == abort_at) begin
          rst = 1'b1;
          #1;
          check_all_zero("abort");
          exp_q.delete();
          return;
        end
        for (int c = 0; c < stall_len; c++) begin
          if (c > 0) @(negedge clk);
          check_eq("stall_pix_ready", pix_ready, 1);
          check_eq("stall_we", we, 0);
          @(posedge clk); #1;
        end
      end else if (rand_gaps) begin
        pix_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      pix_valid = 1'b1;
      pix_data  = pix[i];
      got = 1'b0;
      for (int b = 0; b < 100 && !got; b++) begin
        @(negedge clk);
        got = pix_ready;
        @(posedge clk); #1;
      end
      check_eq("handshake", got, 1);
    end
    pix_valid = 1'b0;
  endtask

  task automatic begin_frame();
    build_model();
    @(posedge clk); #1; scramble = 1'b1;
    @(posedge clk); #1; scramble = 1'b0;
    done_cnt = 0;
    extra_wr = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
  endtask

  task automatic run_frame(input int stall_at, input int stall_len, input bit rand_gaps,
                           input bit mid_start, input int exp_cycles);
    int cyc;
    bit seen;
    begin_frame();
    fork
      drive_frame(stall_at, stall_len, -1, rand_gaps);
      begin
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 3000) begin
          @(posedge clk); #1;
          cyc++;
          seen = done;
        end
      end
      if (mid_start) begin
        repeat (40) begin @(posedge clk); #1; end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    check_eq("done_seen", seen, 1);
    check_eq("busy_at_done", busy, 0);
    if (exp_cycles > 0) check_eq("done_latency", cyc, exp_cycles);
    repeat (6) begin @(posedge clk); #1; end
    check_eq("done_pulses", done_cnt, 1);
    check_eq("writes_missing", exp_q.size(), 0);
    check_eq("writes_extra", extra_wr, 0);
    check_eq("pixels_accepted", hs_cnt, NPIX);
    check_eq("img_6_8", mem[6][8], integ[6][8]);
    check_eq("img_3_4", mem[3][4], integ[3][4]);
    check_eq("img_1_1", mem[1][1], integ[1][1]);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    fill_pix(0);
    run_frame(-1, 0, 1'b0, 1'b0, 159);
    check_eq("ones_6_8", mem[6][8], 48);
    check_eq("ones_2_3", mem[2][3], 6);

    fill_pix(1);
    run_frame(-1, 0, 1'b0, 1'b0, 159);
    check_eq("max_6_8", mem[6][8], 3121200);
    check_eq("max_1_1", mem[1][1], 65025);

    fill_pix(0);
    run_frame(10, 5, 1'b0, 1'b1, 164);
    check_eq("stall_6_8", mem[6][8], 48);

    fill_pix(2);
    begin_frame();
    drive_frame(-1, 0, 20, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("in_reset");
    rst = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    check_eq("abort_done", done_cnt, 0);
    check_eq("abort_writes", extra_wr, 0);
    check_eq("abort_busy", busy, 0);

    fill_pix(2);
    run_frame(-1, 0, 1'b0, 1'b0, 159);

    fill_pix(2);
    run_frame(-1, 0, 1'b1, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
